// File: rtl/imem_loader_if.sv
// Bus between imem_loader and its host/CPU: load byte stream, fetch port and status.
// A byte moves on a rising clk edge where byte_valid && byte_ready; byte_ready never depends on byte_valid.
interface imem_loader_if #(
    parameter int AW = 6
) ();
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_data;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [2:0]    state;

    modport master (
        output start, byte_valid, byte_data, fetch_addr,
        input  byte_ready, fetch_data, cpu_hold, done, err, state
    );

    modport slave (
        input  start, byte_valid, byte_data, fetch_addr,
        output byte_ready, fetch_data, cpu_hold, done, err, state
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: clears memory to NOP_WORD, then fills it from a byte stream.
// Optional trailing XOR checksum byte is enabled with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] NOP_WORD = 32'h00000013,
    parameter int          AW       = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    localparam int DEPTH = 2 ** AW;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        CLEAR = 3'd0, IDLE = 3'd1, COUNT = 3'd2, DATA = 3'd3, CHK = 3'd4, DONE = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        CLEAR = 3'd0, IDLE = 3'd1, COUNT = 3'd2, DATA = 3'd3, DONE = 3'd5
    } state_t;
`endif

    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   n_words;
    logic [1:0]    lane;
    logic [23:0]   asm_q;
    logic          pending;
    logic          ready_q;
    logic          hold_q;
    logic          done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic          err_q;
    logic [7:0]    csum_q;
`endif

    logic [31:0]   mem [DEPTH];
    logic          accept;
    logic          last_byte;
    logic          last_word;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [31:0]   mem_wd;

    assign accept    = ready_q & bus.byte_valid;
    assign last_byte = (lane == 2'd3);
    // wr_ptr is one bit wider than the address so a full 2**AW-word load never wraps
    assign last_word = ((wr_ptr + (AW+1)'(1)) == n_words);

    function automatic logic [AW:0] words_of(input logic [7:0] b);
        if (b == 8'd0 || 32'(b) > DEPTH) return (AW+1)'(DEPTH);
        return (AW+1)'(b);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            wr_ptr  <= '0;
            n_words <= '0;
            lane    <= 2'd0;
            asm_q   <= '0;
            pending <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err_q   <= 1'b0;
            csum_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + AW'(1);
                    if (&clr_ptr) begin
                        if (pending) begin
                            state   <= COUNT;
                            ready_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            hold_q <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                    if (bus.start) begin
                        state   <= CLEAR;
                        pending <= 1'b1;
                        hold_q  <= 1'b1;
                        clr_ptr <= '0;
                        wr_ptr  <= '0;
                        lane    <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        err_q   <= 1'b0;
                        csum_q  <= '0;
`endif
                    end
                end
                COUNT: begin
                    if (accept) begin
                        n_words <= words_of(bus.byte_data);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.byte_data;
`endif
                        if (last_byte) begin
                            lane   <= 2'd0;
                            wr_ptr <= wr_ptr + (AW+1)'(1);
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state   <= CHK;
`else
                                state   <= DONE;
                                ready_q <= 1'b0;
                                hold_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end
                        end else begin
                            lane  <= lane + 2'd1;
                            asm_q <= {bus.byte_data, asm_q[23:8]};
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        err_q   <= (bus.byte_data != csum_q);
                        state   <= DONE;
                        ready_q <= 1'b0;
                        hold_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state   <= IDLE;
                    pending <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    // a failed checksum keeps the CPU stalled until the next good load
                    hold_q  <= err_q;
`else
                    hold_q  <= 1'b0;
`endif
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    ready_q <= 1'b0;
                    hold_q  <= 1'b1;
                end
            endcase
        end
    end

    // Write port: the clear sweep, or the fourth byte of a word completing it.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_ptr;
        mem_wd = NOP_WORD;
        if (state == CLEAR) begin
            mem_we = 1'b1;
        end else if (state == DATA && accept && last_byte) begin
            mem_we = 1'b1;
            mem_wa = wr_ptr[AW-1:0];
            mem_wd = {bus.byte_data, asm_q};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && rst_n) mem[mem_wa] <= mem_wd;
    end

    assign bus.fetch_data = mem[bus.fetch_addr];
    assign bus.byte_ready = ready_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
    assign bus.state      = state;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: clear sweep, loads, saturation, mid-load reset, start during load.
module tb_imem_loader;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   done_cnt;
    logic [7:0]  run_xor;
    logic [31:0] exp_q[$];

    imem_loader_if #(.AW(6)) bus ();

    imem_loader #(.NOP_WORD(32'h00000013), .AW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        while (bus.byte_ready !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        n_tests++;
        if (t >= 200) begin
            n_fail++;
            $display("FAIL byte_ready_wait: byte_ready=%b after %0d cycles, required 1", bus.byte_ready, t);
        end
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b);
        run_xor = run_xor ^ b;
        send_byte(b);
    endtask

    task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
    endtask

    task automatic do_start();
        run_xor   = 8'h00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_hold: got %b, required 1", bus.cpu_hold); end
        n_tests++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", bus.byte_ready); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", bus.done); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", bus.err); end
        n_tests++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d, required 0", bus.state); end
        rst_n = 1'b1;
        cyc = 0;
        while (bus.cpu_hold === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        n_tests++; if (cyc != 64) begin n_fail++; $display("FAIL clear_len: hold high %0d cycles, required 64", cyc); end
        n_tests++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL clear_idle: state %0d, required 1", bus.state); end
        n_tests++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b, required 0", bus.byte_ready); end
        for (int a = 0; a < 64; a++) begin
            bus.fetch_addr = 6'(a);
            #1;
            n_tests++;
            if (bus.fetch_data !== 32'h00000013) begin
                n_fail++;
                $display("FAIL clear_nop[%0d]: got %h, required 00000013", a, bus.fetch_data);
            end
        end
        tick();
    endtask

    task automatic test_basic_load();
        done_cnt = 0;
        do_start();
        n_tests++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL load_hold: got %b, required 1", bus.cpu_hold); end
        n_tests++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL load_clear: state %0d, required 0", bus.state); end
        send_byte(8'h02);
        send_data(8'h93); send_data(8'h00); send_data(8'h50); send_data(8'h00);
        send_data(8'h13); send_data(8'h81); send_data(8'h30); send_data(8'h00);
        send_csum();
        tick();
        tick();
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done: %0d pulses, required 1", done_cnt); end
        n_tests++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_hold: got %b, required 0", bus.cpu_hold); end
        n_tests++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL basic_idle: state %0d, required 1", bus.state); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b, required 0", bus.err); end
        exp_q.delete();
        exp_q.push_back(32'h00500093);
        exp_q.push_back(32'h00308113);
        for (int a = 2; a < 64; a++) exp_q.push_back(32'h00000013);
        for (int a = 0; a < 64; a++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            bus.fetch_addr = 6'(a);
            #1;
            n_tests++;
            if (bus.fetch_data !== e) begin
                n_fail++;
                $display("FAIL basic_mem[%0d]: got %h, required %h", a, bus.fetch_data, e);
            end
        end
        tick();
    endtask

    task automatic test_start_during_data();
        done_cnt = 0;
        do_start();
        send_byte(8'h02);
        send_data(8'h01); send_data(8'h02);
        bus.start = 1'b1;
        repeat (5) tick();
        bus.start = 1'b0;
        n_tests++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL stall_state: state %0d, required 3", bus.state); end
        n_tests++; if (bus.byte_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got %b, required 1", bus.byte_ready); end
        n_tests++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got %b, required 1", bus.cpu_hold); end
        send_data(8'h03); send_data(8'h04);
        send_data(8'h05); send_data(8'h06); send_data(8'h07); send_data(8'h08);
        send_csum();
        tick();
        tick();
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL sdd_done: %0d pulses, required 1", done_cnt); end
        n_tests++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL sdd_idle: state %0d, required 1", bus.state); end
        bus.fetch_addr = 6'd0; #1;
        n_tests++; if (bus.fetch_data !== 32'h04030201) begin n_fail++; $display("FAIL sdd_mem0: got %h, required 04030201", bus.fetch_data); end
        bus.fetch_addr = 6'd1; #1;
        n_tests++; if (bus.fetch_data !== 32'h08070605) begin n_fail++; $display("FAIL sdd_mem1: got %h, required 08070605", bus.fetch_data); end
        bus.fetch_addr = 6'd2; #1;
        n_tests++; if (bus.fetch_data !== 32'h00000013) begin n_fail++; $display("FAIL sdd_mem2: got %h, required 00000013", bus.fetch_data); end
        tick();
    endtask

    task automatic test_max_count();
        done_cnt = 0;
        do_start();
        send_byte(8'h00);
        for (int k = 0; k < 256; k++) begin
            send_data(8'(k));
            tick();
        end
        send_csum();
        tick();
        tick();
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL max_done: %0d pulses, required 1", done_cnt); end
        n_tests++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL max_idle: state %0d, required 1", bus.state); end
        exp_q.delete();
        for (int w = 0; w < 64; w++)
            exp_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        for (int a = 0; a < 64; a++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            bus.fetch_addr = 6'(a);
            #1;
            n_tests++;
            if (bus.fetch_data !== e) begin
                n_fail++;
                $display("FAIL max_mem[%0d]: got %h, required %h", a, bus.fetch_data, e);
            end
        end
        tick();
    endtask

    task automatic test_saturate();
        done_cnt = 0;
        do_start();
        send_byte(8'hC8);
        for (int k = 0; k < 256; k++) send_data(~8'(k));
        send_csum();
        tick();
        tick();
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL sat_done: %0d pulses, required 1", done_cnt); end
        n_tests++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL sat_hold: got %b, required 0", bus.cpu_hold); end
        bus.fetch_addr = 6'd0; #1;
        n_tests++; if (bus.fetch_data !== 32'hFCFDFEFF) begin n_fail++; $display("FAIL sat_mem0: got %h, required fcfdfeff", bus.fetch_data); end
        bus.fetch_addr = 6'd1; #1;
        n_tests++; if (bus.fetch_data !== 32'hF8F9FAFB) begin n_fail++; $display("FAIL sat_mem1: got %h, required f8f9fafb", bus.fetch_data); end
        bus.fetch_addr = 6'd63; #1;
        n_tests++; if (bus.fetch_data !== 32'h00010203) begin n_fail++; $display("FAIL sat_mem63: got %h, required 00010203", bus.fetch_data); end
        tick();
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        done_cnt = 0;
        do_start();
        send_byte(8'h03);
        send_data(8'h11); send_data(8'h22); send_data(8'h33); send_data(8'h44);
        bus.fetch_addr = 6'd0; #1;
        n_tests++; if (bus.fetch_data !== 32'h44332211) begin n_fail++; $display("FAIL mid_word0: got %h, required 44332211", bus.fetch_data); end
        send_data(8'h55); send_data(8'h66);
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL mid_rst_state: state %0d, required 0", bus.state); end
        n_tests++; if (bus.byte_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b, required 0", bus.byte_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
        while (bus.cpu_hold === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        n_tests++; if (cyc != 64) begin n_fail++; $display("FAIL mid_clear_len: hold high %0d cycles, required 64", cyc); end
        n_tests++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL mid_idle: state %0d, required 1", bus.state); end
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL mid_done: %0d pulses, required 0", done_cnt); end
        for (int a = 0; a < 64; a++) begin
            bus.fetch_addr = 6'(a);
            #1;
            n_tests++;
            if (bus.fetch_data !== 32'h00000013) begin
                n_fail++;
                $display("FAIL mid_nop[%0d]: got %h, required 00000013", a, bus.fetch_data);
            end
        end
        tick();
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        done_cnt = 0;
        do_start();
        send_byte(8'h01);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        send_byte(8'h12);
        tick();
        tick();
        n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL csum_bad_err: got %b, required 1", bus.err); end
        n_tests++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL csum_bad_hold: got %b, required 1", bus.cpu_hold); end
        n_tests++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL csum_bad_idle: state %0d, required 1", bus.state); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL csum_bad_done: %0d pulses, required 1", done_cnt); end
        do_start();
        send_byte(8'h01);
        send_data(8'h13); send_data(8'h00); send_data(8'h00); send_data(8'h00);
        send_byte(8'h13);
        tick();
        tick();
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL csum_ok_err: got %b, required 0", bus.err); end
        n_tests++; if (bus.cpu_hold !== 1'b0) begin n_fail++; $display("FAIL csum_ok_hold: got %b, required 0", bus.cpu_hold); end
        bus.fetch_addr = 6'd0; #1;
        n_tests++; if (bus.fetch_data !== 32'h00000013) begin n_fail++; $display("FAIL csum_ok_mem0: got %h, required 00000013", bus.fetch_data); end
        tick();
    endtask
`endif

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        done_cnt       = 0;
        run_xor        = 8'h00;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.fetch_addr = 6'd0;
        test_reset();
        test_basic_load();
        test_start_during_data();
        test_max_count();
        test_saturate();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
